fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_pkg.sv | 22 ++
 rtl/fetch_stage_adder.sv | 12 +
 rtl/fetch_stage.sv | 157 +++++++++++++++
 tb/tb_fetch_stage.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the fetch stage.
//   fetch_st_e : fetch FSM states (BOOT, FETCH, HOLD)
//   NOP_WORD   : canonical bubble instruction (addi x0,x0,0)
//   if_id_t    : IF/ID pipeline register contents
package fetch_stage_pkg;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } fetch_st_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic        valid;
    } if_id_t;

endpackage

// File: rtl/fetch_stage_adder.sv
// 32-bit modulo adder (carry-out discarded).
//   i_a, i_b : operands
//   o_sum    : (i_a + i_b) mod 2^32
module fetch_stage_adder (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_sum
);

    assign o_sum = i_a + i_b;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID register and one-entry skid buffer.
// A fetched word that arrives while the pipeline is stalled is parked in the
// skid buffer (HOLD) so the memory is not asked for it again.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   stall_f, flush_d    : hazard unit hold / bubble controls
//   pc_src_e, pc_target_e : execute-stage redirect
//   imem_req/addr/ready/rdata : instruction memory handshake
//   instr_d, pc_d, pc_plus4_d, valid_d : IF/ID register
//   misalign_d          : only with FETCH_MISALIGN_CHECK_EN defined; flags the
//                         first entry after a redirect to a non word-aligned target
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_f,
    input  logic        flush_d,
    input  logic        pc_src_e,
    input  logic [31:0] pc_target_e,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc_plus4_d,
`ifdef FETCH_MISALIGN_CHECK_EN
    output logic        misalign_d,
`endif
    output logic        valid_d
);

    fetch_st_e   r_state, w_state_nxt;
    logic [31:0] r_pc, w_pc_nxt;
    logic [31:0] r_skid, w_skid_nxt;
    if_id_t      r_ifid, w_ifid_nxt;
    logic [31:0] w_pc_plus4;
    logic        w_load;        // load a real instruction into IF/ID
    logic        w_bub;         // load a bubble into IF/ID
    logic [31:0] w_load_instr;
    logic        w_redirect;

    fetch_stage_adder u_pc_add (
        .i_a   (r_pc),
        .i_b   (32'd4),
        .o_sum (w_pc_plus4)
    );

    // BOOT ignores redirects: nothing in flight can have produced one.
    assign w_redirect = pc_src_e && (r_state != ST_BOOT);

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_BOOT;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_skid_nxt   = r_skid;
        w_load       = 1'b0;
        w_bub        = 1'b0;
        w_load_instr = imem_rdata;
        case (r_state)
            ST_BOOT: begin
                w_state_nxt = ST_FETCH;
                w_bub       = 1'b1;
            end
            ST_FETCH: begin
                if (imem_ready) begin
                    if (!stall_f) begin
                        w_load   = 1'b1;
                        w_pc_nxt = w_pc_plus4;
                    end else begin
                        w_skid_nxt  = imem_rdata;
                        w_state_nxt = ST_HOLD;
                    end
                end else if (!stall_f) begin
                    w_bub = 1'b1;
                end
            end
            ST_HOLD: begin
                if (!stall_f) begin
                    w_load       = 1'b1;
                    w_load_instr = r_skid;
                    w_pc_nxt     = w_pc_plus4;
                    w_state_nxt  = ST_FETCH;
                end
            end
            default: w_state_nxt = ST_FETCH;
        endcase

        if (w_redirect) begin
            w_pc_nxt    = pc_target_e & 32'hFFFF_FFFC;
            w_skid_nxt  = NOP_INSTR;
            w_state_nxt = ST_FETCH;
            w_load      = 1'b0;
            w_bub       = 1'b1;
        end else if (flush_d) begin
            // PC/FSM keep their normal progress; only the entry is killed.
            w_load = 1'b0;
            w_bub  = 1'b1;
        end

        w_ifid_nxt = r_ifid;
        if (w_load) begin
            w_ifid_nxt = '{instr: w_load_instr, pc: r_pc, pc_plus4: w_pc_plus4, valid: 1'b1};
        end else if (w_bub) begin
            w_ifid_nxt.instr = NOP_INSTR;
            w_ifid_nxt.valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc   <= RESET_PC;
            r_skid <= NOP_INSTR;     // NOP content marks the buffer empty
            r_ifid <= '{instr: NOP_INSTR, pc: 32'd0, pc_plus4: 32'd0, valid: 1'b0};
        end else begin
            r_pc   <= w_pc_nxt;
            r_skid <= w_skid_nxt;
            r_ifid <= w_ifid_nxt;
        end
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    // r_mis_pend remembers a misaligned redirect until the first real entry.
    logic r_mis_pend, r_misalign;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mis_pend <= 1'b0;
            r_misalign <= 1'b0;
        end else if (w_redirect) begin
            r_mis_pend <= (pc_target_e[1:0] != 2'b00);
            r_misalign <= 1'b0;
        end else if (w_load) begin
            r_misalign <= r_mis_pend;
            r_mis_pend <= 1'b0;
        end else if (w_bub) begin
            r_misalign <= 1'b0;
        end
    end
    assign misalign_d = r_misalign;
`endif

    assign imem_req   = (r_state == ST_FETCH);
    assign imem_addr  = r_pc;
    assign instr_d    = r_ifid.instr;
    assign pc_d       = r_ifid.pc;
    assign pc_plus4_d = r_ifid.pc_plus4;
    assign valid_d    = r_ifid.valid;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset, stall_f, flush_d, pc_src_e, imem_ready;
    logic [31:0] pc_target_e, imem_rdata, imem_addr;
    logic        imem_req, valid_d;
    logic [31:0] instr_d, pc_d, pc_plus4_d;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        misalign_d;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Memory model: word at address A is 0xC000_0000 ^ A.
    assign imem_rdata = 32'hC000_0000 ^ imem_addr;

    fetch_stage dut (
        .clk         (clk),
        .reset       (reset),
        .stall_f     (stall_f),
        .flush_d     (flush_d),
        .pc_src_e    (pc_src_e),
        .pc_target_e (pc_target_e),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .instr_d     (instr_d),
        .pc_d        (pc_d),
        .pc_plus4_d  (pc_plus4_d),
`ifdef FETCH_MISALIGN_CHECK_EN
        .misalign_d  (misalign_d),
`endif
        .valid_d     (valid_d)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; stall_f = 0; flush_d = 0; pc_src_e = 0;
        pc_target_e = 32'h0; imem_ready = 1'b1;
        step(); step();
        chk("rst_instr", instr_d, 32'h0000_0013);
        chk("rst_valid", {31'd0, valid_d}, 32'd0);
        chk("rst_pc_d", pc_d, 32'd0);
        chk("rst_pc4_d", pc_plus4_d, 32'd0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
    endtask

    // Reset release with memory always ready, then stall into HOLD at 0x10.
    task automatic test_boot_and_skid();
        reset = 1'b0;
        chk("boot_req", {31'd0, imem_req}, 32'd0);
        step();
        chk("fetch_req", {31'd0, imem_req}, 32'd1);
        chk("fetch_addr0", imem_addr, 32'h0);
        step();
        chk("seq_pc0", pc_d, 32'h0);
        chk("seq_v0", {31'd0, valid_d}, 32'd1);
        chk("seq_instr0", instr_d, 32'hC000_0000);
        step();
        chk("seq_pc4", pc_d, 32'h4);
        step();
        chk("seq_pc8", pc_d, 32'h8);
        chk("seq_pc4_8", pc_plus4_d, 32'hC);
        step();
        chk("seq_pcC", pc_d, 32'hC);
        chk("pre_stall_addr", imem_addr, 32'h10);
        stall_f = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_pc_d", pc_d, 32'hC);
            chk("hold_req", {31'd0, imem_req}, 32'd0);
            chk("hold_addr", imem_addr, 32'h10);
        end
        stall_f = 1'b0;
        step();
        chk("skid_instr", instr_d, 32'hC000_0010);
        chk("skid_pc_d", pc_d, 32'h10);
        chk("skid_valid", {31'd0, valid_d}, 32'd1);
        chk("skid_pc_f", imem_addr, 32'h14);
        chk("skid_req", {31'd0, imem_req}, 32'd1);
    endtask

    task automatic test_redirect_over_stall();
        pc_src_e = 1'b1; pc_target_e = 32'h100; stall_f = 1'b1;
        step();
        pc_src_e = 1'b0; stall_f = 1'b0;
        chk("redir_addr", imem_addr, 32'h100);
        chk("redir_valid", {31'd0, valid_d}, 32'd0);
        chk("redir_instr", instr_d, 32'h0000_0013);
        step();
        chk("redir_pc_d", pc_d, 32'h100);
        chk("redir_instr2", instr_d, 32'hC000_0100);
        chk("redir_pc4_d", pc_plus4_d, 32'h104);
    endtask

    task automatic test_bubbles();
        imem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("bub_instr", instr_d, 32'h0000_0013);
            chk("bub_valid", {31'd0, valid_d}, 32'd0);
            chk("bub_addr", imem_addr, 32'h104);
            chk("bub_pc_d", pc_d, 32'h100);
        end
        imem_ready = 1'b1;
    endtask

    task automatic test_flush();
        flush_d = 1'b1; stall_f = 1'b1;
        step();
        // flush overrides the stall hold of IF/ID; the word goes to the skid
        chk("flush_valid", {31'd0, valid_d}, 32'd0);
        chk("flush_req", {31'd0, imem_req}, 32'd0);
        stall_f = 1'b0;
        step();
        chk("flush_hold_valid", {31'd0, valid_d}, 32'd0);
        chk("flush_addr", imem_addr, 32'h108);
        flush_d = 1'b0;
        step();
        chk("post_flush_pc_d", pc_d, 32'h108);
        chk("post_flush_valid", {31'd0, valid_d}, 32'd1);
    endtask

    task automatic test_wrap_misalign();
        pc_src_e = 1'b1; pc_target_e = 32'hFFFF_FFFC;
        step();
        pc_src_e = 1'b0;
        step();
        chk("wrap_pc_d", pc_d, 32'hFFFF_FFFC);
        chk("wrap_pc4_d", pc_plus4_d, 32'h0);
        chk("wrap_addr", imem_addr, 32'h0);
        pc_src_e = 1'b1; pc_target_e = 32'h102;
        step();
        pc_src_e = 1'b0;
        chk("mis_addr", imem_addr, 32'h100);
        step();
        chk("mis_pc_d", pc_d, 32'h100);
`ifdef FETCH_MISALIGN_CHECK_EN
        chk("mis_flag_set", {31'd0, misalign_d}, 32'd1);
`endif
        step();
        chk("mis_next_pc_d", pc_d, 32'h104);
`ifdef FETCH_MISALIGN_CHECK_EN
        chk("mis_flag_clr", {31'd0, misalign_d}, 32'd0);
`endif
    endtask

    // Redirect discards a parked word; reset aborts HOLD and redirects.
    task automatic test_hold_abort();
        stall_f = 1'b1;
        step();
        chk("h_req", {31'd0, imem_req}, 32'd0);
        pc_src_e = 1'b1; pc_target_e = 32'h200;
        step();
        pc_src_e = 1'b0;
        chk("h_redir_req", {31'd0, imem_req}, 32'd1);
        chk("h_redir_addr", imem_addr, 32'h200);
        chk("h_redir_valid", {31'd0, valid_d}, 32'd0);
        step();
        chk("h_stall_req", {31'd0, imem_req}, 32'd0);
        reset = 1'b1; pc_src_e = 1'b1; pc_target_e = 32'h300;
        step();
        reset = 1'b0; pc_src_e = 1'b0; stall_f = 1'b0;
        chk("h_rst_req", {31'd0, imem_req}, 32'd0);
        chk("h_rst_addr", imem_addr, 32'h0);
        chk("h_rst_pc_d", pc_d, 32'h0);
        chk("h_rst_valid", {31'd0, valid_d}, 32'd0);
        step(); step();
        chk("h_rst_first", instr_d, 32'hC000_0000);
        chk("h_rst_first_v", {31'd0, valid_d}, 32'd1);
    endtask

    initial begin
        test_reset();
        test_boot_and_skid();
        test_redirect_over_stall();
        test_bubbles();
        test_flush();
        test_wrap_misalign();
        test_hold_abort();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
